wr_512b_to_bram: RTL and testbench

//  Writes one 512-bit image row into the shared BRAM as 16 sequential 32-bit word writes via the top BRAM wr controller.

---
 rtl/wr_512b_to_bram_pkg.sv | 33 +++
 rtl/wr_512b_to_bram.sv | 116 +++++++++++
 tb/tb_wr_512b_to_bram.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wr_512b_to_bram_pkg.sv
// Shared row/word geometry for the 512-bit row writer and reader. Both sides
// must use the same BRAM address map, so it is defined only here.
package wr_512b_to_bram_pkg;

  localparam int DATA_W     = 32;
  localparam int ROW_W      = 512;
  localparam int ROW_ADDR_W = 9;
  localparam int WORDS      = ROW_W / DATA_W;
  localparam int IDX_W      = $clog2(WORDS);
  localparam int ADDR_W     = ROW_ADDR_W + IDX_W;
  localparam int SEL_W      = $clog2(ROW_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEL,
    S_REQ,
    S_DONE
  } wr_state_e;

  // Row request captured in IDLE; later input changes do not affect it.
  typedef struct packed {
    logic [ROW_ADDR_W-1:0] row;
    logic [ROW_W-1:0]      data;
    logic [WORDS-1:0]      mask;
  } wr_snap_t;

  // BRAM word address: row number in the upper bits, word index in the lower bits.
  function automatic logic [ADDR_W-1:0] row_word_addr(input logic [ROW_ADDR_W-1:0] row,
                                                      input logic [IDX_W-1:0]      idx);
    return {row, idx};
  endfunction

endpackage

// File: rtl/wr_512b_to_bram.sv
// Writes one 512-bit row into BRAM as up to 16 masked 32-bit word writes.
// Word 0 is the most significant word of the row.
import wr_512b_to_bram_pkg::*;

module wr_512b_to_bram (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_trig,
  output logic                  o_done,
  input  logic [ROW_ADDR_W-1:0] i_wr_row_num,
  input  logic [ROW_W-1:0]      i_wr_data_512b,
  input  logic [WORDS-1:0]      i_wr_word_mask,
  output logic [ADDR_W-1:0]     o_wr_to_bram_addr,
  output logic [DATA_W-1:0]     o_wr_to_bram_data,
  output logic                  o_wr_to_bram_trig,
  input  logic                  i_wr_to_bram_done
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  wr_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  wr_snap_t          snap_q, snap_d;
  logic              done_q, done_d;
  logic              trig_q, trig_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [SEL_W-1:0]  wbase;
  logic [DATA_W-1:0] word_sel;

  assign wbase    = SEL_W'(ROW_W - 1 - DATA_W * int'(idx_q));
  assign word_sel = snap_q.data[wbase -: DATA_W];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      trig_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    done_d  = done_q;
    trig_d  = trig_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        trig_d = 1'b0;
        if (i_trig) begin
          snap_d  = '{row: i_wr_row_num, data: i_wr_data_512b, mask: i_wr_word_mask};
          idx_d   = '0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (snap_q.mask[idx_q]) begin
          addr_d  = row_word_addr(snap_q.row, idx_q);
          data_d  = word_sel;
          trig_d  = 1'b1;
          state_d = S_REQ;
        end else if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_REQ: begin
        // Dropping trig on the done edge guarantees one low cycle between words.
        if (i_wr_to_bram_done) begin
          trig_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEL;
          end
        end
      end
      S_DONE: begin
        trig_d = 1'b0;
        done_d = 1'b1;
        if (!i_trig) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_done            = done_q;
  assign o_wr_to_bram_trig = trig_q;
  assign o_wr_to_bram_addr = addr_q;
  assign o_wr_to_bram_data = data_q;

endmodule

// File: tb/tb_wr_512b_to_bram.sv
// Directed bench for the 512-bit row writer: a BRAM write-controller model with
// programmable latency, a word-array BRAM model and hand-derived expectations.
module tb_wr_512b_to_bram;
  import wr_512b_to_bram_pkg::*;

  logic                  i_clk = 1'b0;
  logic                  i_rstn = 1'b0;
  logic                  i_trig = 1'b0;
  logic                  o_done;
  logic [ROW_ADDR_W-1:0] row_num = '0;
  logic [ROW_W-1:0]      row_data = '0;
  logic [WORDS-1:0]      row_mask = '0;
  logic [ADDR_W-1:0]     bram_addr;
  logic [DATA_W-1:0]     bram_data;
  logic                  bram_trig;
  logic                  bram_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  wr_512b_to_bram dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .i_trig            (i_trig),
    .o_done            (o_done),
    .i_wr_row_num      (row_num),
    .i_wr_data_512b    (row_data),
    .i_wr_word_mask    (row_mask),
    .o_wr_to_bram_addr (bram_addr),
    .o_wr_to_bram_data (bram_data),
    .o_wr_to_bram_trig (bram_trig),
    .i_wr_to_bram_done (bram_done)
  );

  // Controller model: done on the n_lat-th cycle trig is high; 'spur' drives
  // done high whenever trig is low to exercise stray-done immunity.
  int          n_lat = 1;
  bit          spur = 1'b0;
  int          hcnt = 0;
  int          wcnt = 0;
  int          tcyc = 0;
  logic [31:0] mem [8192];
  logic [12:0] log_addr [256];

  initial for (int a = 0; a < 8192; a++) mem[a] = '0;

  always @(negedge i_clk) begin
    if (bram_trig) begin
      tcyc++;
      hcnt++;
      if (hcnt >= n_lat) begin
        bram_done = 1'b1;
        mem[bram_addr] = bram_data;
        log_addr[wcnt % 256] = bram_addr;
        wcnt++;
      end else begin
        bram_done = 1'b0;
      end
    end else begin
      hcnt = 0;
      bram_done = spur;
    end
  end

  function automatic logic [31:0] wgen(input int seed, input int k);
    if (seed == 0) return 32'(k);
    return {8'(seed), 8'(k), 8'(~seed), 8'(k + 8'h40)};
  endfunction

  // Word 0 ends up in the top 32 bits.
  function automatic logic [ROW_W-1:0] mkrow(input int seed);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < WORDS; k++) r = {r[ROW_W-DATA_W-1:0], wgen(seed, k)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a row at the current negedge (next posedge is edge 0) and returns
  // the edge index at which o_done was seen high.
  task automatic run_row(input logic [8:0] r, input int seed, input logic [15:0] m,
                         input int n, input bit scramble, output int edges);
    n_lat    = n;
    row_num  = r;
    row_data = mkrow(seed);
    row_mask = m;
    i_trig   = 1'b1;
    edges    = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk);
      edges++;
      if (scramble && edges == 2) begin
        row_num  = r ^ 9'h1;
        row_data = ~row_data;
        row_mask = 16'hFFFF;
      end
      if (o_done) break;
    end
  endtask

  initial begin
    int e, w0, t0;
    logic [ROW_W-1:0] rb;

    // Reset state and idle immunity to stray done
    repeat (3) @(negedge i_clk);
    chk("rst_done", 512'(o_done), 512'd0);
    chk("rst_trig", 512'(bram_trig), 512'd0);
    chk("rst_addr", 512'(bram_addr), 512'd0);
    chk("rst_data", 512'(bram_data), 512'd0);
    i_rstn = 1'b1;
    spur = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("idle_spur_done", 512'(o_done), 512'd0);
    chk("idle_spur_trig", 512'(bram_trig), 512'd0);
    spur = 1'b0;
    @(negedge i_clk);

    // 1: row 5, full mask, N=1
    w0 = wcnt;
    run_row(9'd5, 0, 16'hFFFF, 1, 1'b0, e);
    chk("t1_edges", 512'(e), 512'd32);
    chk("t1_nwrites", 512'(wcnt - w0), 512'd16);
    chk("t1_first_addr", 512'(log_addr[w0 % 256]), 512'h050);
    chk("t1_last_addr", 512'(log_addr[(w0 + 15) % 256]), 512'h05F);
    for (int k = 0; k < 16; k++) chk($sformatf("t1_word%0d", k), 512'(mem[13'h050 + k]), 512'(k));
    repeat (3) @(negedge i_clk);
    chk("t1_done_held", 512'(o_done), 512'd1);
    i_trig = 1'b0;
    @(negedge i_clk);
    chk("t1_done_drop", 512'(o_done), 512'd0);
    chk("t1_trig_idle", 512'(bram_trig), 512'd0);

    // 2: row 511, mask 0x8001, N=3
    w0 = wcnt;
    run_row(9'd511, 2, 16'h8001, 3, 1'b0, e);
    chk("t2_edges", 512'(e), 512'd22);
    chk("t2_nwrites", 512'(wcnt - w0), 512'd2);
    chk("t2_word0", 512'(mem[13'h1FF0]), 512'(wgen(2, 0)));
    chk("t2_word15", 512'(mem[13'h1FFF]), 512'(wgen(2, 15)));
    chk("t2_word1_untouched", 512'(mem[13'h1FF1]), 512'd0);
    i_trig = 1'b0;
    @(negedge i_clk);

    // 3: empty mask
    w0 = wcnt;
    t0 = tcyc;
    run_row(9'd7, 3, 16'h0000, 1, 1'b0, e);
    chk("t3_edges", 512'(e), 512'd16);
    chk("t3_nwrites", 512'(wcnt - w0), 512'd0);
    chk("t3_trig_cycles", 512'(tcyc - t0), 512'd0);
    repeat (2) @(negedge i_clk);
    chk("t3_done_held", 512'(o_done), 512'd1);
    i_trig = 1'b0;
    @(negedge i_clk);
    chk("t3_done_drop", 512'(o_done), 512'd0);

    // 4: stray done pulses plus input changes after start; mask 0x8421, N=2
    spur = 1'b1;
    w0 = wcnt;
    run_row(9'd8, 4, 16'h8421, 2, 1'b1, e);
    chk("t4_edges", 512'(e), 512'd24);
    chk("t4_nwrites", 512'(wcnt - w0), 512'd4);
    chk("t4_w0", 512'(mem[13'h080]), 512'(wgen(4, 0)));
    chk("t4_w5", 512'(mem[13'h085]), 512'(wgen(4, 5)));
    chk("t4_w10", 512'(mem[13'h08A]), 512'(wgen(4, 10)));
    chk("t4_w15", 512'(mem[13'h08F]), 512'(wgen(4, 15)));
    chk("t4_w1_untouched", 512'(mem[13'h081]), 512'd0);
    chk("t4_row9_untouched", 512'(mem[13'h090]), 512'd0);
    repeat (2) @(negedge i_clk);
    chk("t4_done_spur", 512'(o_done), 512'd1);
    i_trig = 1'b0;
    @(negedge i_clk);
    chk("t4_idle", 512'(o_done), 512'd0);
    spur = 1'b0;
    @(negedge i_clk);

    // 5: async reset while word 7 of row 3 is outstanding
    n_lat    = 5;
    row_num  = 9'd3;
    row_data = mkrow(5);
    row_mask = 16'hFFFF;
    i_trig   = 1'b1;
    e = 0;
    while (!(bram_trig && bram_addr == 13'h037) && e < 1000) begin
      @(negedge i_clk);
      e++;
    end
    chk("t5_reached_word7", 512'(e < 1000), 512'd1);
    #1;
    i_rstn = 1'b0;
    i_trig = 1'b0;
    #1;
    chk("t5_trig_async", 512'(bram_trig), 512'd0);
    chk("t5_done_async", 512'(o_done), 512'd0);
    chk("t5_partial_w6", 512'(mem[13'h036]), 512'(wgen(5, 6)));
    chk("t5_partial_w7", 512'(mem[13'h037]), 512'd0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    w0 = wcnt;
    run_row(9'd3, 6, 16'hFFFF, 1, 1'b0, e);
    chk("t5_edges", 512'(e), 512'd32);
    chk("t5_nwrites", 512'(wcnt - w0), 512'd16);
    for (int k = 0; k < 16; k++) chk($sformatf("t5_word%0d", k), 512'(mem[13'h030 + k]), 512'(wgen(6, k)));

    // 6: back-to-back with a single low cycle on i_trig; row 6, N=2
    i_trig = 1'b0;
    @(negedge i_clk);
    w0 = wcnt;
    run_row(9'd6, 7, 16'hFFFF, 2, 1'b0, e);
    chk("t6_edges", 512'(e), 512'd48);
    chk("t6_first_addr", 512'(log_addr[w0 % 256]), 512'h060);
    rb = '0;
    for (int k = 0; k < 16; k++) rb = {rb[ROW_W-DATA_W-1:0], mem[13'h060 + k]};
    chk("t6_readback", rb, mkrow(7));
    i_trig = 1'b0;
    @(negedge i_clk);
    chk("t6_idle", 512'(o_done), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
